// File: rtl/mem_xbar_if.sv
// mem_xbar_if: bus bundle between the crossbar and its masters/slaves.
// The master modport is the environment side: masters drive requests, slaves drive responses.
interface mem_xbar_if #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned NUM_S  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_M-1:0]        m_req;
  logic [NUM_M-1:0]        m_we;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M*DATA_W-1:0] m_rdata;
  logic [NUM_M-1:0]        m_ready;
  logic [NUM_S-1:0]        s_req;
  logic                    s_we;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [NUM_S*DATA_W-1:0] s_rdata;
  logic [NUM_S-1:0]        s_ready;

  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_ready, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    output m_rdata, m_ready, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_xbar.sv
// mem_xbar: round-robin NUM_M-master x NUM_S-slave shared-bus crossbar, one transaction in flight.
// Defining XBAR_TIMEOUT_EN adds a BUSY timeout (TIMEOUT_CYC) with a sticky timeout_flag.
module mem_xbar #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned NUM_S  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = '0
`ifdef XBAR_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  mem_xbar_if.slave   bus,
  output logic [15:0] dec_err_cnt,
  output logic        timeout_flag
);

  localparam int unsigned MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DERR = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]              state,     state_d;
  logic [MW-1:0]           owner,     owner_d;
  logic [MW-1:0]           rr_ptr,    rr_d;
  logic [SW-1:0]           sel,       sel_d;
  logic [NUM_S-1:0]        s_req_q,   s_req_d;
  logic                    s_we_q,    s_we_d;
  logic [ADDR_W-1:0]       s_addr_q,  s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
  logic [NUM_M-1:0]        m_ready_q, m_ready_d;
  logic [NUM_M*DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic [15:0]             derr_q,    derr_d;

  logic                    grant_vld;
  logic [MW-1:0]           grant;
  logic [MW-1:0]           cand;
  logic [ADDR_W-1:0]       addr_sel;
  logic                    hit;
  logic [SW-1:0]           hit_idx;

`ifdef XBAR_TIMEOUT_EN
  logic [31:0]             tmo_q, tmo_d;
  logic                    tflag_q, tflag_d;
`endif

  assign bus.s_req    = s_req_q;
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m_ready  = m_ready_q;
  assign bus.m_rdata  = m_rdata_q;
  assign dec_err_cnt  = derr_q;
`ifdef XBAR_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // Next-state, arbitration and decode
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    rr_d      = rr_ptr;
    sel_d     = sel;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_ready_d = '0;
    m_rdata_d = '0;
    derr_d    = derr_q;
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    hit       = 1'b0;
    hit_idx   = '0;
`ifdef XBAR_TIMEOUT_EN
    tmo_d     = tmo_q;
    tflag_d   = tflag_q;
`endif

    // Round-robin scan starting at rr_ptr; first requester wins
    for (int unsigned i = 0; i < NUM_M; i++) begin
      cand = MW'((32'(rr_ptr) + 32'(i)) % NUM_M);
      if (!grant_vld && bus.m_req[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end

    addr_sel = bus.m_addr[32'(grant)*ADDR_W +: ADDR_W];

    // Descending scan so the lowest matching slave index is left in hit_idx
    for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
      if ((addr_sel & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end

    case (state)
      IDLE: begin
`ifdef XBAR_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (grant_vld) begin
          owner_d   = grant;
          s_addr_d  = addr_sel;
          s_we_d    = bus.m_we[grant];
          s_wdata_d = bus.m_wdata[32'(grant)*DATA_W +: DATA_W];
          if (hit) begin
            sel_d            = hit_idx;
            s_req_d          = '0;
            s_req_d[hit_idx] = 1'b1;
            state_d          = BUSY;
          end else begin
            state_d = DERR;
          end
        end
      end
      BUSY: begin
        if (bus.s_ready[sel]) begin
          s_req_d          = '0;
          m_ready_d[owner] = 1'b1;
          if (!s_we_q)
            m_rdata_d[32'(owner)*DATA_W +: DATA_W] = bus.s_rdata[32'(sel)*DATA_W +: DATA_W];
          state_d = RESP;
        end
`ifdef XBAR_TIMEOUT_EN
        else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
          s_req_d          = '0;
          m_ready_d[owner] = 1'b1;
          m_rdata_d[32'(owner)*DATA_W +: DATA_W] = DATA_W'(32'hDEAD_BEEF);
          tflag_d          = 1'b1;
          state_d          = RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      DERR: begin
        m_ready_d[owner] = 1'b1;
        if (derr_q != 16'hFFFF)
          derr_d = derr_q + 16'd1;
        state_d = RESP;
      end
      RESP: begin
        rr_d    = MW'((32'(owner) + 32'd1) % NUM_M);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      s_req_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_ready_q <= '0;
      m_rdata_q <= '0;
      derr_q    <= '0;
`ifdef XBAR_TIMEOUT_EN
      tmo_q     <= '0;
      tflag_q   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_ptr    <= rr_d;
      sel       <= sel_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
      derr_q    <= derr_d;
`ifdef XBAR_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tflag_q   <= tflag_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// tb_mem_xbar: directed and randomized checks of mem_xbar against a transaction-level model.
// Slave map: s0 0x0000_0xxx, s1 0x4000_0xxx, s2 0x4000_1xxx, s3 0x4xxx_xxxx (overlaps s1/s2).
module tb_mem_xbar;
  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;
  localparam logic [NS*32-1:0] BASE_P = {32'h4000_0000, 32'h4000_1000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK_P = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dec_err_cnt;
  logic        timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mbase [NS];
  logic [31:0] mmask [NS];

  mem_xbar_if #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_xbar #(
    .NUM_M(NM), .NUM_S(NS), .ADDR_W(32), .DATA_W(32),
    .SLV_BASE(BASE_P), .SLV_MASK(MASK_P)
`ifdef XBAR_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dec_err_cnt(dec_err_cnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Reference decode: lowest-index slave whose masked address equals its base
  function automatic int model_decode(input logic [31:0] a);
    int r;
    r = -1;
    for (int i = 0; i < int'(NS); i++)
      if (r < 0 && (a & mmask[i]) == mbase[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_req   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ready = '0;
    bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Advance until the crossbar reacts (slave request or master completion), bounded
  task automatic wait_react(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.s_req == '0 && bus.m_ready == '0 && cyc < 32);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (bus.s_req !== 4'b0) begin n_fail++; $display("FAIL reset_sreq: got %b want 0000", bus.s_req); end
    n_checks++; if (bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL reset_mready: got %b want 00", bus.m_ready); end
    n_checks++; if (bus.m_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_mrdata: got %h want 0", bus.m_rdata); end
    n_checks++; if (dec_err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_decerr: got %h want 0", dec_err_cnt); end
    n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_tflag: got %b want 0", timeout_flag); end
    n_checks++; if ({bus.s_we, bus.s_addr, bus.s_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_sbus: got %h want 0", {bus.s_we, bus.s_addr, bus.s_wdata}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    bus.m_we[0]        = 1'b0;
    bus.m_addr[31:0]   = 32'h4000_0004;
    bus.m_req[0]       = 1'b1;
    step();
    for (int c = 1; c <= 3; c++) begin
      n_checks++; if (bus.s_req !== 4'b0010) begin n_fail++; $display("FAIL read_sreq_c%0d: got %b want 0010", c, bus.s_req); end
      n_checks++; if (bus.m_ready !== 2'b00) begin n_fail++; $display("FAIL read_mready_c%0d: got %b want 00", c, bus.m_ready); end
      if (c == 3) begin
        bus.s_ready[1]      = 1'b1;
        bus.s_rdata[63:32]  = 32'h1234_5678;
      end
      step();
    end
    bus.s_ready = '0;
    n_checks++; if (bus.m_ready !== 2'b01) begin n_fail++; $display("FAIL read_mready: got %b want 01", bus.m_ready); end
    n_checks++; if (bus.m_rdata !== 64'h0000_0000_1234_5678) begin n_fail++; $display("FAIL read_mrdata: got %h want 0000000012345678", bus.m_rdata); end
    n_checks++; if (bus.s_req !== 4'b0) begin n_fail++; $display("FAIL read_sreq_drop: got %b want 0000", bus.s_req); end
    n_checks++; if (bus.s_addr !== 32'h4000_0004 || bus.s_we !== 1'b0) begin n_fail++; $display("FAIL read_saddr: got %h/%b want 40000004/0", bus.s_addr, bus.s_we); end
    bus.m_req[0] = 1'b0;
    step();
    n_checks++; if (bus.m_ready !== 2'b00) begin n_fail++; $display("FAIL read_pulse_len: got %b want 00", bus.m_ready); end
  endtask

  task automatic test_write();
    bus.m_we[1]         = 1'b1;
    bus.m_addr[63:32]   = 32'h0000_0010;
    bus.m_wdata[63:32]  = 32'hA5A5_A5A5;
    bus.m_req[1]        = 1'b1;
    step();
    n_checks++; if (bus.s_req !== 4'b0001) begin n_fail++; $display("FAIL write_sreq: got %b want 0001", bus.s_req); end
    n_checks++; if (bus.s_we !== 1'b1) begin n_fail++; $display("FAIL write_swe: got %b want 1", bus.s_we); end
    n_checks++; if (bus.s_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL write_swdata: got %h want a5a5a5a5", bus.s_wdata); end
    n_checks++; if (bus.s_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL write_saddr: got %h want 00000010", bus.s_addr); end
    bus.s_ready[0]     = 1'b1;
    bus.s_rdata[31:0]  = 32'hFFFF_FFFF;
    step();
    bus.s_ready = '0;
    n_checks++; if (bus.m_ready !== 2'b10) begin n_fail++; $display("FAIL write_mready: got %b want 10", bus.m_ready); end
    n_checks++; if (bus.m_rdata !== 64'h0) begin n_fail++; $display("FAIL write_mrdata: got %h want 0", bus.m_rdata); end
    bus.m_req[1] = 1'b0;
    bus.m_we[1]  = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    int cyc;
    logic [31:0] d;
    do_reset();
    bus.m_addr  = {32'h4000_1008, 32'h0000_0020};
    bus.m_req   = 2'b11;
    // Both keep requesting: expect M0, then M1, then M0 again
    for (int r = 0; r < 3; r++) begin
      wait_react(cyc);
      n_checks++; if (cyc >= 32) begin n_fail++; $display("FAIL arb_wait_r%0d: no reaction after %0d cycles", r, cyc); end
      if (r == 1) begin
        n_checks++; if (bus.s_req !== 4'b0100 || bus.s_addr !== 32'h4000_1008) begin n_fail++; $display("FAIL arb_grant_r%0d: got %b/%h want 0100/40001008", r, bus.s_req, bus.s_addr); end
        d = $urandom;
        bus.s_ready[2]     = 1'b1;
        bus.s_rdata[95:64] = d;
        step();
        bus.s_ready = '0;
        n_checks++; if (bus.m_ready !== 2'b10 || bus.m_rdata !== {d, 32'h0}) begin n_fail++; $display("FAIL arb_resp_r%0d: got %b/%h want 10/%h", r, bus.m_ready, bus.m_rdata, {d, 32'h0}); end
      end else begin
        n_checks++; if (bus.s_req !== 4'b0001 || bus.s_addr !== 32'h0000_0020) begin n_fail++; $display("FAIL arb_grant_r%0d: got %b/%h want 0001/00000020", r, bus.s_req, bus.s_addr); end
        d = $urandom;
        bus.s_ready[0]    = 1'b1;
        bus.s_rdata[31:0] = d;
        step();
        bus.s_ready = '0;
        n_checks++; if (bus.m_ready !== 2'b01 || bus.m_rdata !== {32'h0, d}) begin n_fail++; $display("FAIL arb_resp_r%0d: got %b/%h want 01/%h", r, bus.m_ready, bus.m_rdata, {32'h0, d}); end
      end
    end
    bus.m_req = '0;
    step();
  endtask

  task automatic test_decode_error();
    do_reset();
    bus.m_addr[31:0] = 32'hF000_0000;
    bus.m_req[0]     = 1'b1;
    step();
    n_checks++; if (bus.s_req !== 4'b0 || bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL derr_c1: got sreq %b mready %b want 0000/00", bus.s_req, bus.m_ready); end
    step();
    n_checks++; if (bus.m_ready !== 2'b01) begin n_fail++; $display("FAIL derr_mready: got %b want 01", bus.m_ready); end
    n_checks++; if (bus.m_rdata !== 64'h0) begin n_fail++; $display("FAIL derr_mrdata: got %h want 0", bus.m_rdata); end
    n_checks++; if (bus.s_req !== 4'b0) begin n_fail++; $display("FAIL derr_sreq: got %b want 0000", bus.s_req); end
    n_checks++; if (dec_err_cnt !== 16'd1) begin n_fail++; $display("FAIL derr_cnt: got %0d want 1", dec_err_cnt); end
    bus.m_req[0] = 1'b0;
    step();
    n_checks++; if (bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL derr_pulse_len: got %b want 00", bus.m_ready); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] d;
    bus.m_addr[63:32] = 32'h4000_1000;
    bus.m_req[1]      = 1'b1;
    step();
    n_checks++; if (bus.s_req !== 4'b0100) begin n_fail++; $display("FAIL rstbusy_sreq: got %b want 0100", bus.s_req); end
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.s_req !== 4'b0) begin n_fail++; $display("FAIL rstbusy_async: got %b want 0000", bus.s_req); end
    bus.m_req = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++; if (bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL rstbusy_mready_c%0d: got %b want 00", c, bus.m_ready); end
    end
    rst = 1'b0;
    bus.m_addr[31:0] = 32'h4000_0008;
    bus.m_req[0]     = 1'b1;
    step();
    n_checks++; if (bus.s_req !== 4'b0010) begin n_fail++; $display("FAIL rstbusy_new_sreq: got %b want 0010", bus.s_req); end
    d = $urandom;
    bus.s_ready[1]     = 1'b1;
    bus.s_rdata[63:32] = d;
    step();
    bus.s_ready = '0;
    n_checks++; if (bus.m_ready !== 2'b01 || bus.m_rdata !== {32'h0, d}) begin n_fail++; $display("FAIL rstbusy_new_resp: got %b/%h want 01/%h", bus.m_ready, bus.m_rdata, {32'h0, d}); end
    bus.m_req = '0;
    step();
  endtask

`ifdef XBAR_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    do_reset();
    bus.m_addr[31:0] = 32'h4000_0010;
    bus.m_req[0]     = 1'b1;
    step();
    busy = 0;
    while (bus.s_req != '0 && busy < 40) begin
      busy++;
      step();
    end
    n_checks++; if (busy !== 8) begin n_fail++; $display("FAIL tmo_busy_len: got %0d want 8", busy); end
    n_checks++; if (bus.m_ready !== 2'b01) begin n_fail++; $display("FAIL tmo_mready: got %b want 01", bus.m_ready); end
    n_checks++; if (bus.m_rdata !== 64'h0000_0000_DEAD_BEEF) begin n_fail++; $display("FAIL tmo_mrdata: got %h want deadbeef", bus.m_rdata); end
    n_checks++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", timeout_flag); end
    bus.m_req = '0;
    step();
    step();
    n_checks++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout_flag); end
  endtask
`endif

  task automatic test_random();
    int          rr, win, dec, cyc, nd, exp_derr;
    logic [1:0]  pend;
    logic [31:0] a [NM];
    logic [31:0] wd [NM];
    logic        w [NM];
    logic [31:0] d;
    logic [3:0]  exp_sreq;
    logic [63:0] exp_rdata;
    do_reset();
    rr = 0; pend = '0; exp_derr = 0;
    for (int t = 0; t < 60; t++) begin
      for (int m = 0; m < int'(NM); m++) begin
        if (!pend[m] && ($urandom_range(0, 9) < 7 || (pend == '0 && m == int'(NM) - 1))) begin
          case ($urandom_range(0, 5))
            0: a[m] = {20'h00000, 12'($urandom)};
            1: a[m] = {20'h40000, 12'($urandom)};
            2: a[m] = {20'h40001, 12'($urandom)};
            3: a[m] = {4'h4, 28'($urandom)};
            4: a[m] = {4'h8, 28'($urandom)};
            default: a[m] = $urandom;
          endcase
          w[m]  = 1'($urandom);
          wd[m] = $urandom;
          pend[m] = 1'b1;
          bus.m_addr[m*32 +: 32]  = a[m];
          bus.m_wdata[m*32 +: 32] = wd[m];
          bus.m_we[m]  = w[m];
          bus.m_req[m] = 1'b1;
        end
      end
      win = -1;
      for (int k = 0; k < int'(NM); k++)
        if (win < 0 && pend[(rr + k) % int'(NM)]) win = (rr + k) % int'(NM);
      dec = model_decode(a[win]);
      wait_react(cyc);
      n_checks++; if (cyc >= 32) begin n_fail++; $display("FAIL rnd_wait_t%0d: no reaction after %0d cycles", t, cyc); end
      exp_rdata = '0;
      if (dec >= 0) begin
        exp_sreq = 4'(1) << dec;
        n_checks++; if (bus.s_req !== exp_sreq || bus.s_addr !== a[win] || bus.s_we !== w[win]) begin n_fail++; $display("FAIL rnd_req_t%0d: got %b/%h/%b want %b/%h/%b", t, bus.s_req, bus.s_addr, bus.s_we, exp_sreq, a[win], w[win]); end
        if (w[win]) begin
          n_checks++; if (bus.s_wdata !== wd[win]) begin n_fail++; $display("FAIL rnd_wdata_t%0d: got %h want %h", t, bus.s_wdata, wd[win]); end
        end
        nd = $urandom_range(0, 3);
        for (int c = 0; c < nd; c++) begin
          bus.s_ready = 4'($urandom) & ~exp_sreq;
          bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
          step();
          n_checks++; if (bus.s_req !== exp_sreq || bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL rnd_hold_t%0d: got %b/%b want %b/00", t, bus.s_req, bus.m_ready, exp_sreq); end
        end
        d = $urandom;
        bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
        bus.s_rdata[dec*32 +: 32] = d;
        bus.s_ready = exp_sreq;
        step();
        bus.s_ready = '0;
        if (!w[win]) exp_rdata[win*32 +: 32] = d;
      end else begin
        exp_derr++;
        n_checks++; if (dec_err_cnt !== 16'(exp_derr)) begin n_fail++; $display("FAIL rnd_derr_t%0d: got %0d want %0d", t, dec_err_cnt, exp_derr); end
      end
      n_checks++; if (bus.m_ready !== 2'(2'(1) << win) || bus.m_rdata !== exp_rdata || bus.s_req !== 4'b0) begin n_fail++; $display("FAIL rnd_resp_t%0d: got %b/%h/%b want %b/%h/0000", t, bus.m_ready, bus.m_rdata, bus.s_req, 2'(2'(1) << win), exp_rdata); end
      pend[win]        = 1'b0;
      bus.m_req[win]   = 1'b0;
      bus.m_we[win]    = 1'b0;
      rr = (win + 1) % int'(NM);
    end
    step();
    n_checks++; if (bus.m_ready !== 2'b0) begin n_fail++; $display("FAIL rnd_idle: got %b want 00", bus.m_ready); end
`ifndef XBAR_TIMEOUT_EN
    n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL rnd_tflag: got %b want 0", timeout_flag); end
`endif
  endtask

  initial begin
    mbase[0] = 32'h0000_0000; mmask[0] = 32'hFFFF_F000;
    mbase[1] = 32'h4000_0000; mmask[1] = 32'hFFFF_F000;
    mbase[2] = 32'h4000_1000; mmask[2] = 32'hFFFF_F000;
    mbase[3] = 32'h4000_0000; mmask[3] = 32'hF000_0000;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_decode_error();
    test_reset_mid_busy();
`ifdef XBAR_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
